md_sched: RTL and testbench
===========================

// Module: md_sched
// PURPOSE
// Sequencer for the pipeline's multiply/divide unit (HI/LO). Accepts MULT/MULTU/DIV/DIVU from the E stage,
// runs a fixed-latency busy window, commits HI/LO on completion, and serves MTHI/MTLO writes and MFHI/MFLO reads.
// Raises a D-stage stall when an MD-class instruction reaches D while the unit is starting or busy.
// Sits beside the ALU in DATAPATH; its control inputs come from the E-stage CTRL decode.
// PARAMETERS
// WIDTH        32  operand / HI / LO width
// MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
// DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
// clk       in   1      rising-edge clock
// reset     in   1      synchronous, active-high reset
// start     in   1      E-stage instr is MULT/MULTU/DIV/DIVU (one-cycle pulse per instr)
// multctrl  in   3      op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, others = no-op
// src_a     in   WIDTH  rs value (forwarded); dividend / multiplicand / MTHI-MTLO data
// src_b     in   WIDTH  rt value (forwarded); divisor / multiplier
// muwe      in   2      [1]=MTHI write, [0]=MTLO write, from src_a
// mure      in   2      read select: 2'b10 HI, 2'b01 LO, else 0
// ismu      in   1      D-stage instr uses MD unit (mult/div/mf*/mt*)
// busy      out  1      count != 0 or start
// stall     out  1      ismu & busy
// md_out    out  WIDTH  MFHI/MFLO result to E-stage result mux
// hi, lo    out  WIDTH  architectural HI/LO
// BEHAVIOUR
// - Reset: state IDLE, count=0, hi=lo=0, pending=0; busy=stall=0; md_out=0.
// - FSM: IDLE -> BUSY on start with valid multctrl at edge k; count loaded with MULT_CYCLES or DIV_CYCLES;
//   operands' result computed at k and held in pend_hi/pend_lo. BUSY: count decrements each edge;
//   edge where count 1->0 writes hi/lo from pend and returns to IDLE. hi/lo hold old values during BUSY.
// - Timing: busy high in start cycle k and cycles k+1..k+N (count!=0); new hi/lo visible in cycle k+N+1.
// - start with invalid multctrl (4..7): ignored, busy=start only that cycle, no state change.
// - start while BUSY: cannot occur (stall). If it does, ignored; count and pend unchanged (assertion flags).
// - muwe: applied at edge only in IDLE with start=0; both bits set writes both HI and LO with src_a.
//   muwe during BUSY or with start same cycle: ignored (assertion flags).
// - md_out: combinational from current hi/lo per mure; mure 2'b11 or 2'b00 -> 0. No bypass of a
//   same-cycle muwe write (stall guarantees ordering).
// - Arithmetic: MULT signed 64-bit product, MULTU unsigned; hi=prod[63:32], lo=prod[31:0].
//   DIV signed, truncate toward zero: lo=quotient, hi=remainder (sign of dividend). DIVU unsigned.
//   Divisor 0: DIV/DIVU still occupy DIV_CYCLES; hi/lo left unchanged at commit.
//   Signed DIV 0x80000000 / -1: lo=0x80000000, hi=0.
// - Reset mid-operation: aborts immediately; IDLE, count=0, hi=lo=0, pending discarded.
// - stall is combinational from ismu and busy; no registered delay.
// STRUCTURE
// - md_pkg: op encodings (MD_MULT..MD_DIVU), mure/muwe bit constants, FSM state enum {IDLE,BUSY}.
// - Sub-module md_arith: combinational {op,a,b} -> {hi,lo,div0}; md_sched holds FSM, counter, regs.
// TESTING
// - reset; MULT a=0xFFFFFFFD b=2, start at k -> busy k..k+5, cycle k+6: hi=0xFFFFFFFF lo=0xFFFFFFFA.
// - MULTU a=b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE lo=0x00000001.
// - DIV a=7 b=0xFFFFFFFE -> busy 11 cycles incl. start, then lo=0xFFFFFFFD hi=1; DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF hi=1.
// - DIV b=0 with hi=0x11,lo=0x22 -> busy 11 cycles, hi/lo stay 0x11/0x22.
// - ismu=1 during start cycle and busy window -> stall=1 through k+N, 0 at k+N+1; MTLO 0x1234 then mure=01 -> md_out=0x1234.
// - reset asserted at k+3 of a DIV -> next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, HI/LO port bit
// positions and the FSM state type.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;

    localparam int MUWE_HI_BIT = 1;
    localparam int MUWE_LO_BIT = 0;

    localparam logic [1:0] MURE_HI = 2'b10;
    localparam logic [1:0] MURE_LO = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
// Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div0
);

    logic [2*WIDTH-1:0] w_a_sx;
    logic [2*WIDTH-1:0] w_b_sx;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_b_safe;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_q_u;
    logic [WIDTH-1:0]   w_r_u;

    // Sign-extended operands give the correct low 2*WIDTH bits of the signed product.
    assign w_a_sx   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_sx   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    assign o_div0   = (i_b == '0);
    assign w_b_safe = o_div0 ? WIDTH'(1) : i_b;

    assign w_a_neg  = i_a[WIDTH-1];
    assign w_b_neg  = w_b_safe[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
    assign w_b_mag  = w_b_neg ? (~w_b_safe + WIDTH'(1)) : w_b_safe;
    assign w_q_mag  = w_a_mag / w_b_mag;
    assign w_r_mag  = w_a_mag % w_b_mag;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
    assign w_r_s    = w_a_neg ? (~w_r_mag + WIDTH'(1)) : w_r_mag;

    assign w_q_u    = i_a / w_b_safe;
    assign w_r_u    = i_a % w_b_safe;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        case (i_op)
            MD_MULT: begin
                o_hi = w_prod_s[2*WIDTH-1:WIDTH];
                o_lo = w_prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                o_hi = w_prod_u[2*WIDTH-1:WIDTH];
                o_lo = w_prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                o_hi = w_r_s;
                o_lo = w_q_s;
            end
            MD_DIVU: begin
                o_hi = w_r_u;
                o_lo = w_q_u;
            end
            default: begin
                o_hi = '0;
                o_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: fixed-latency busy window, HI/LO commit, MTHI/MTLO writes,
// MFHI/MFLO read mux and the D-stage stall.
//   state | meaning
//   IDLE  | no operation in flight; MTHI/MTLO writes accepted
//   BUSY  | down-counter running; HI/LO commit from pending on terminal count
module md_sched
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       multctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       muwe,
    input  logic [1:0]       mure,
    input  logic             ismu,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] md_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_t         r_state;
    md_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_pend_hi;
    logic [WIDTH-1:0]  r_pend_lo;
    logic              r_pend_div0;
    logic              w_load;
    logic              w_commit;
    logic              w_mt_ok;
    logic [WIDTH-1:0]  w_res_hi;
    logic [WIDTH-1:0]  w_res_lo;
    logic              w_res_div0;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .i_op   (multctrl),
        .i_a    (src_a),
        .i_b    (src_b),
        .o_hi   (w_res_hi),
        .o_lo   (w_res_lo),
        .o_div0 (w_res_div0)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && is_md_op(multctrl)) begin
                    w_state_nxt = BUSY;
                    w_count_nxt = is_div_op(multctrl) ? DIV_LOAD : MULT_LOAD;
                    w_load      = 1'b1;
                end
            end
            BUSY: begin
                w_count_nxt = r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // HI/LO writes only land when nothing is in flight or starting this cycle.
    assign w_mt_ok = (r_state == IDLE) && !start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_pend_hi   <= '0;
            r_pend_lo   <= '0;
            r_pend_div0 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_load) begin
                r_pend_hi   <= w_res_hi;
                r_pend_lo   <= w_res_lo;
                r_pend_div0 <= w_res_div0;
            end
            if (w_commit && !r_pend_div0) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (w_mt_ok) begin
                if (muwe[MUWE_HI_BIT]) r_hi <= src_a;
                if (muwe[MUWE_LO_BIT]) r_lo <= src_a;
            end
        end
    end

    assign busy  = (r_count != '0) || start;
    assign stall = ismu && busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        md_out = '0;
        case (mure)
            MURE_HI: md_out = r_hi;
            MURE_LO: md_out = r_lo;
            default: md_out = '0;
        endcase
    end

    a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(start && (r_state == BUSY)));

    a_no_mt_while_busy: assert property (@(posedge clk) disable iff (reset)
        !((muwe != 2'b00) && ((r_state == BUSY) || start)));

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus tasks queue per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_md_sched;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    localparam int K_BUSY  = 0;
    localparam int K_STALL = 1;
    localparam int K_HI    = 2;
    localparam int K_LO    = 3;
    localparam int K_MDOUT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    multctrl;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [1:0]    muwe;
    logic [1:0]    mure;
    logic          ismu;
    logic          busy;
    logic          stall;
    logic [W-1:0]  md_out;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    md_sched #(
        .WIDTH       (W),
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .multctrl (multctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .muwe     (muwe),
        .mure     (mure),
        .ismu     (ismu),
        .busy     (busy),
        .stall    (stall),
        .md_out   (md_out),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    logic [31:0] act;

    always @(posedge clk) cyc = cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_BUSY:  return "busy";
            K_STALL: return "stall";
            K_HI:    return "hi";
            K_LO:    return "lo";
            default: return "md_out";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_BUSY:  return {31'b0, busy};
            K_STALL: return {31'b0, stall};
            K_HI:    return hi;
            K_LO:    return lo;
            default: return md_out;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks = n_checks + 1;
            if (e.cyc != cyc) begin
                n_errors = n_errors + 1;
                $display("FAIL t%0d %s missed: due cycle %0d, now %0d", e.tag, kname(e.kind), e.cyc, cyc);
            end else begin
                act = actual(e.kind);
                if (act !== e.exp) begin
                    n_errors = n_errors + 1;
                    $display("FAIL t%0d %s cycle %0d: got %h expected %h", e.tag, kname(e.kind), cyc, act, e.exp);
                end
            end
        end
    end

    task automatic push(input int c, input int k, input int tag, input logic [31:0] v);
        exp_t x;
        x.cyc  = c;
        x.kind = k;
        x.tag  = tag;
        x.exp  = v;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start op at current cycle k, ismu held high; checks busy/stall/hold/commit window.
    task automatic do_op(input int tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] eh, input logic [31:0] el);
        int k;
        k        = cyc;
        start    = 1'b1;
        multctrl = op;
        src_a    = a;
        src_b    = b;
        ismu     = 1'b1;
        mure     = 2'b10;
        for (int c = k; c <= k + n; c++) begin
            push(c, K_BUSY,  tag, 32'd1);
            push(c, K_STALL, tag, 32'd1);
            push(c, K_HI,    tag, m_hi);
            push(c, K_LO,    tag, m_lo);
            push(c, K_MDOUT, tag, m_hi);
        end
        push(k + n + 1, K_BUSY,  tag, 32'd0);
        push(k + n + 1, K_STALL, tag, 32'd0);
        push(k + n + 1, K_HI,    tag, eh);
        push(k + n + 1, K_LO,    tag, el);
        push(k + n + 1, K_MDOUT, tag, eh);
        m_hi = eh;
        m_lo = el;
        tick();
        start    = 1'b0;
        multctrl = 3'd0;
        repeat (n) tick();
        tick();
        ismu = 1'b0;
        mure = 2'b00;
    endtask

    task automatic mt(input int tag, input logic [1:0] w, input logic [31:0] d);
        muwe  = w;
        src_a = d;
        if (w[1]) m_hi = d;
        if (w[0]) m_lo = d;
        push(cyc + 1, K_HI, tag, m_hi);
        push(cyc + 1, K_LO, tag, m_lo);
        tick();
        muwe = 2'b00;
    endtask

    task automatic rd(input int tag, input logic [1:0] r, input logic [31:0] v);
        mure = r;
        push(cyc, K_MDOUT, tag, v);
        tick();
        mure = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        multctrl = 3'd0;
        src_a    = '0;
        src_b    = '0;
        muwe     = 2'b00;
        mure     = 2'b00;
        ismu     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        ismu  = 1'b1;
        mure  = 2'b10;
        push(cyc, K_BUSY,  0, 32'd0);
        push(cyc, K_STALL, 0, 32'd0);
        push(cyc, K_HI,    0, 32'd0);
        push(cyc, K_LO,    0, 32'd0);
        push(cyc, K_MDOUT, 0, 32'd0);
        tick();
        ismu = 1'b0;
        mure = 2'b00;

        do_op(1, 3'd0, 32'hFFFFFFFD, 32'h00000002, NM, 32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op(2, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, NM, 32'hFFFFFFFE, 32'h00000001);
        do_op(3, 3'd2, 32'h00000007, 32'hFFFFFFFE, ND, 32'h00000001, 32'hFFFFFFFD);
        do_op(4, 3'd3, 32'hFFFFFFFF, 32'h00000002, ND, 32'h00000001, 32'h7FFFFFFF);

        mt(5, 2'b10, 32'h00000011);
        mt(6, 2'b01, 32'h00000022);
        rd(7, 2'b10, 32'h00000011);
        rd(7, 2'b01, 32'h00000022);
        rd(7, 2'b11, 32'h00000000);

        do_op(8, 3'd2, 32'h00000064, 32'h00000000, ND, 32'h00000011, 32'h00000022);
        do_op(9, 3'd2, 32'h80000000, 32'hFFFFFFFF, ND, 32'h00000000, 32'h80000000);

        mt(10, 2'b01, 32'h00001234);
        rd(10, 2'b01, 32'h00001234);

        // Invalid op code: busy for the start cycle only, nothing else moves.
        start    = 1'b1;
        multctrl = 3'd5;
        src_a    = 32'h00000009;
        src_b    = 32'h00000003;
        ismu     = 1'b1;
        push(cyc,     K_BUSY,  11, 32'd1);
        push(cyc,     K_STALL, 11, 32'd1);
        push(cyc + 1, K_BUSY,  11, 32'd0);
        push(cyc + 1, K_STALL, 11, 32'd0);
        push(cyc + 1, K_HI,    11, m_hi);
        push(cyc + 1, K_LO,    11, m_lo);
        tick();
        start    = 1'b0;
        multctrl = 3'd0;
        tick();
        ismu = 1'b0;

        mt(12, 2'b11, 32'h0000ABCD);

        // Reset in cycle k+3 of a DIV aborts it with no later commit.
        k        = cyc;
        start    = 1'b1;
        multctrl = 3'd2;
        src_a    = 32'd100;
        src_b    = 32'd7;
        for (int c = k; c <= k + 3; c++) push(c, K_BUSY, 13, 32'd1);
        push(k + 3, K_HI, 13, m_hi);
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        push(k + 4, K_BUSY, 13, 32'd0);
        push(k + 4, K_HI,   13, 32'd0);
        push(k + 4, K_LO,   13, 32'd0);
        push(k + 12, K_BUSY, 13, 32'd0);
        push(k + 12, K_HI,   13, 32'd0);
        push(k + 12, K_LO,   13, 32'd0);
        repeat (10) tick();

        if (sb_q.size() != 0) begin
            n_errors = n_errors + sb_q.size();
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
